icache: RTL and testbench
=========================

ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter: ICACHE_IDX_W, default 6, log2 of the number of direct-mapped lines; each line holds one 32-bit instruction word.
REQ-002 clk_in  input  1  system clock; all state changes on its rising edge.
REQ-003 rst_in  input  1  reset, asynchronous, active-low: low forces reset immediately, independent of clk_in.
REQ-004 rdy_in  input  1  global ready; when low, all state and outputs hold.
REQ-005 clear  input  1  pipeline flush (mispredict); aborts any outstanding fetch.
REQ-006 if_enable  input  1  fetch request from decoder.
REQ-007 if_addr  input  32  fetch byte address; bits [1:0] ignored.
REQ-008 inst_ready  output  1  one-cycle pulse, inst valid.
REQ-009 inst  output  32  fetched instruction word.
REQ-010 mem_req  output  1  word read request to memctrl, held until mem_ready.
REQ-011 mem_addr  output  32  word-aligned read address ({addr[31:2],2'b00}).
REQ-012 mem_ready  input  1  memctrl word-return pulse.
REQ-013 mem_data  input  32  returned word, valid while mem_ready is high.

Function
REQ-014 Address split: index = addr[ICACHE_IDX_W+1:2], tag = addr[31:ICACHE_IDX_W+2]; per line a valid bit, a tag and a 32-bit data word.
REQ-015 FSM states IDLE, MISS, DROP; reset state IDLE.
REQ-016 IDLE, if_enable=1, clear=0, line valid and tag match (hit): the next cycle drives inst_ready=1 with inst=line data; state stays IDLE; hit latency is exactly 1 cycle.
REQ-017 IDLE, if_enable=1, clear=0, miss: latch the address; from the next cycle drive mem_req=1 and mem_addr=latched word address; go to MISS.
REQ-018 MISS: mem_req and mem_addr stay stable until the cycle mem_ready=1.
REQ-019 MISS with mem_ready=1 and clear=0: write mem_data, the tag and valid=1 into the line; the next cycle drives inst_ready=1 and inst=mem_data; mem_req drops the cycle after mem_ready; go to IDLE.
REQ-020 if_enable is ignored outside IDLE; in IDLE with if_enable=0, no action.
REQ-021 clear=1 in IDLE: any pending inst_ready for the next cycle is suppressed and the request in the same cycle is ignored.
REQ-022 clear=1 in MISS with mem_ready=0: go to DROP with mem_req held, so the memctrl transaction completes.
REQ-023 clear=1 in MISS with mem_ready=1: fill the line and go to IDLE, with no inst_ready.
REQ-024 DROP: on mem_ready=1, fill the line and go to IDLE with no inst_ready; further clears in DROP have no effect.
REQ-025 inst_ready is never high on two consecutive cycles from the same request and is never high in the cycle after a clear.
REQ-026 rdy_in=0: FSM, arrays and output registers hold their values; mem_ready arriving while rdy_in=0 is not consumed (memctrl holds under the same rdy_in).
REQ-027 There is no invalidate port; cache contents survive clear, because instruction memory is read-only.

Reset
REQ-028 On rst_in low: state=IDLE, all valid bits=0, inst_ready=0, inst=0, mem_req=0, mem_addr=0, latched address=0.
REQ-029 Reset asserted during MISS or DROP abandons the transaction immediately; after release the block accepts a new request in the first cycle.
REQ-030 Tag and data arrays need no reset; only the valid bits are cleared.

Verification
REQ-031 Cold miss: reset, if_enable with if_addr=0x0000_0000 -> mem_req=1, mem_addr=0x0; mem_ready after 3 cycles with mem_data=0x0000_0093 -> next cycle inst_ready=1, inst=0x0000_0093.
REQ-032 Hit: then if_enable with if_addr=0x0 -> inst_ready=1 next cycle, mem_req stays 0.
REQ-033 Conflict: fill 0x0000_0000, then request 0x0000_0100 (same index, ICACHE_IDX_W=6) -> miss; re-request 0x0 -> miss again.
REQ-034 Flush mid-miss: miss on 0x0000_1004, clear at cycle 2 -> DROP; mem_ready returns 0xDEAD_BEEF -> no inst_ready; request 0x1004 -> hit returning 0xDEAD_BEEF.
REQ-035 Stall: rdy_in=0 for 5 cycles during MISS -> mem_req and mem_addr unchanged, no inst_ready; resume completes normally.
REQ-036 Async reset: drop rst_in mid-MISS between clock edges -> mem_req=0 immediately; a request after release misses (valid bits cleared).

Source files
------------

// File: rtl/icache.sv
// Direct-mapped instruction cache, one 32-bit word per line, single outstanding
// word fetch to memctrl. A flush during a miss lets the transfer finish and fills the line silently.
module icache #(
  parameter int unsigned ICACHE_IDX_W = 6
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear,
  input  logic        if_enable,
  input  logic [31:0] if_addr,
  output logic        inst_ready,
  output logic [31:0] inst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_data
);

  localparam int unsigned LINES = 1 << ICACHE_IDX_W;
  localparam int unsigned TAG_W = 30 - ICACHE_IDX_W;

  typedef enum logic [1:0] {IDLE, MISS, DROP} state_e;

  state_e                  state_q, state_d;
  logic [LINES-1:0]        valid_q;
  logic [TAG_W-1:0]        tag_q  [LINES];
  logic [31:0]             data_q [LINES];

  logic                    inst_ready_q, inst_ready_d;
  logic [31:0]             inst_q, inst_d;
  logic                    mem_req_q, mem_req_d;
  logic [31:0]             mem_addr_q, mem_addr_d;
  logic [31:0]             addr_q, addr_d;

  logic [ICACHE_IDX_W-1:0] req_idx, fill_idx;
  logic [TAG_W-1:0]        req_tag, fill_tag;
  logic                    hit, fill_en;
  logic                    unused_addr_bits;

  assign req_idx  = if_addr[ICACHE_IDX_W+1:2];
  assign req_tag  = if_addr[31:ICACHE_IDX_W+2];
  assign fill_idx = addr_q[ICACHE_IDX_W+1:2];
  assign fill_tag = addr_q[31:ICACHE_IDX_W+2];
  assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign unused_addr_bits = ^{if_addr[1:0], addr_q[1:0]};

  always_comb begin
    state_d      = state_q;
    inst_ready_d = 1'b0;
    inst_d       = inst_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    addr_d       = addr_q;
    fill_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_enable && !clear) begin
          if (hit) begin
            inst_ready_d = 1'b1;
            inst_d       = data_q[req_idx];
          end else begin
            addr_d     = if_addr;
            mem_req_d  = 1'b1;
            mem_addr_d = {if_addr[31:2], 2'b00};
            state_d    = MISS;
          end
        end
      end
      MISS: begin
        if (mem_ready) begin
          fill_en   = 1'b1;
          mem_req_d = 1'b0;
          state_d   = IDLE;
          if (!clear) begin
            inst_ready_d = 1'b1;
            inst_d       = mem_data;
          end
        end else if (clear) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (mem_ready) begin
          fill_en   = 1'b1;
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // rdy_in low freezes everything, so a mem_ready seen during a stall is not consumed.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      inst_ready_q <= 1'b0;
      inst_q       <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      addr_q       <= '0;
    end else if (rdy_in) begin
      state_q      <= state_d;
      inst_ready_q <= inst_ready_d;
      inst_q       <= inst_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      addr_q       <= addr_d;
      if (fill_en) begin
        valid_q[fill_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rdy_in && fill_en) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= mem_data;
    end
  end

  assign inst_ready = inst_ready_q;
  assign inst       = inst_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;

endmodule

// File: tb/tb_icache.sv
// Bench for icache: directed vector table, hand-written flush/stall/reset sequences,
// then random fetches against a line-level cache model with the bench acting as memctrl.
module tb_icache;

  logic        clk_in, rst_in, rdy_in, clear, if_enable, mem_ready;
  logic [31:0] if_addr, mem_data;
  logic        inst_ready, mem_req;
  logic [31:0] inst, mem_addr;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  icache #(.ICACHE_IDX_W(6)) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .clear      (clear),
    .if_enable  (if_enable),
    .if_addr    (if_addr),
    .inst_ready (inst_ready),
    .inst       (inst),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ready  (mem_ready),
    .mem_data   (mem_data)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] md;
    logic        hit;
    logic [31:0] exp;
    int unsigned lat;
  } vec_t;

  vec_t tbl [12];

  bit          m_valid [64];
  logic [31:0] m_tag   [64];
  logic [31:0] m_data  [64];

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return ((a >> 2) * 32'h9E37_79B9) ^ 32'h1357_2468;
  endfunction

  task automatic reset_dut();
    rst_in = 1'b0; rdy_in = 1'b1; clear = 1'b0; if_enable = 1'b0;
    if_addr = '0; mem_ready = 1'b0; mem_data = '0;
    step(); step();
    chk("rst_inst_ready", {31'b0, inst_ready}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    rst_in = 1'b1;
  endtask

  // One fetch from IDLE to IDLE; misses are served after lat wait cycles.
  task automatic fetch(input logic [31:0] a, input logic exp_hit, input logic [31:0] exp_inst,
                       input logic [31:0] md, input int unsigned lat,
                       input logic do_clr, input logic do_stall);
    logic [31:0] wa;
    wa = a & ~32'h3;
    if_enable = 1'b1; if_addr = a;
    step();
    if_enable = 1'b0; if_addr = $urandom;
    if (exp_hit) begin
      chk("hit_ready", {31'b0, inst_ready}, 32'd1);
      chk("hit_inst", inst, exp_inst);
      chk("hit_no_req", {31'b0, mem_req}, 32'd0);
      step();
      chk("hit_single_pulse", {31'b0, inst_ready}, 32'd0);
    end else begin
      chk("miss_req", {31'b0, mem_req}, 32'd1);
      chk("miss_addr", mem_addr, wa);
      chk("miss_no_ready", {31'b0, inst_ready}, 32'd0);
      for (int unsigned c = 0; c < lat; c++) begin
        if_enable = 1'($urandom % 2);
        if (do_clr) clear = (c == 0) ? 1'b1 : 1'($urandom % 2);
        if (do_stall && !(do_clr && c == 0) && ($urandom % 3 == 0)) begin
          rdy_in = 1'b0; mem_ready = 1'($urandom % 2); mem_data = $urandom;
        end
        step();
        clear = 1'b0; rdy_in = 1'b1; mem_ready = 1'b0;
        chk("wait_req", {31'b0, mem_req}, 32'd1);
        chk("wait_addr", mem_addr, wa);
        chk("wait_no_ready", {31'b0, inst_ready}, 32'd0);
      end
      mem_ready = 1'b1; mem_data = md;
      if (do_clr && lat == 0) clear = 1'b1;
      step();
      mem_ready = 1'b0; clear = 1'b0; if_enable = 1'b0;
      chk("fill_ready", {31'b0, inst_ready}, do_clr ? 32'd0 : 32'd1);
      if (!do_clr) chk("fill_inst", inst, md);
      chk("fill_req_drop", {31'b0, mem_req}, 32'd0);
      step();
      chk("fill_single_pulse", {31'b0, inst_ready}, 32'd0);
    end
  endtask

  initial begin
    tbl[0]  = '{32'h0000_0000, 32'h0000_0093, 1'b0, 32'h0000_0093, 3};
    tbl[1]  = '{32'h0000_0000, 32'h0,         1'b1, 32'h0000_0093, 0};
    tbl[2]  = '{32'h0000_0100, 32'h0000_0011, 1'b0, 32'h0000_0011, 1};
    tbl[3]  = '{32'h0000_0000, 32'h0000_0022, 1'b0, 32'h0000_0022, 2};
    tbl[4]  = '{32'h0000_0004, 32'h0000_0033, 1'b0, 32'h0000_0033, 0};
    tbl[5]  = '{32'h0000_0006, 32'h0,         1'b1, 32'h0000_0033, 0};
    tbl[6]  = '{32'h0000_0100, 32'h0000_0044, 1'b0, 32'h0000_0044, 4};
    tbl[7]  = '{32'h0000_0103, 32'h0,         1'b1, 32'h0000_0044, 0};
    tbl[8]  = '{32'h0000_00FC, 32'h0000_0055, 1'b0, 32'h0000_0055, 1};
    tbl[9]  = '{32'hFFFF_FFFC, 32'h0000_0066, 1'b0, 32'h0000_0066, 2};
    tbl[10] = '{32'h0000_00FC, 32'h0000_0077, 1'b0, 32'h0000_0077, 1};
    tbl[11] = '{32'h0000_0004, 32'h0,         1'b1, 32'h0000_0033, 0};

    reset_dut();
    for (int i = 0; i < 12; i++)
      fetch(tbl[i].addr, tbl[i].hit, tbl[i].exp, tbl[i].md, tbl[i].lat, 1'b0, 1'b0);

    // Flush mid-miss: line is still filled, later request hits.
    fetch(32'h0000_1004, 1'b0, 32'h0, 32'hDEAD_BEEF, 3, 1'b1, 1'b0);
    fetch(32'h0000_1004, 1'b1, 32'hDEAD_BEEF, 32'h0, 0, 1'b0, 1'b0);

    // Clear together with a hitting request.
    if_enable = 1'b1; if_addr = 32'h0000_1004; clear = 1'b1;
    step();
    if_enable = 1'b0; clear = 1'b0;
    chk("clr_idle_no_ready", {31'b0, inst_ready}, 32'd0);
    chk("clr_idle_no_req", {31'b0, mem_req}, 32'd0);

    // Clear coinciding with mem_ready in MISS.
    fetch(32'h0000_2000, 1'b0, 32'h0, 32'h2222_0000, 0, 1'b1, 1'b0);
    fetch(32'h0000_2000, 1'b1, 32'h2222_0000, 32'h0, 0, 1'b0, 1'b0);

    // Stall: mem_ready seen while rdy_in low must not be consumed.
    if_enable = 1'b1; if_addr = 32'h0000_3000;
    step();
    if_enable = 1'b0;
    chk("stall_req_start", {31'b0, mem_req}, 32'd1);
    rdy_in = 1'b0; mem_ready = 1'b1; mem_data = 32'hBAD0_BAD0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_req", {31'b0, mem_req}, 32'd1);
      chk("stall_addr", mem_addr, 32'h0000_3000);
      chk("stall_no_ready", {31'b0, inst_ready}, 32'd0);
    end
    rdy_in = 1'b1; mem_data = 32'h3333_0000;
    step();
    mem_ready = 1'b0;
    chk("stall_resume_ready", {31'b0, inst_ready}, 32'd1);
    chk("stall_resume_inst", inst, 32'h3333_0000);
    chk("stall_resume_req", {31'b0, mem_req}, 32'd0);
    step();

    // Asynchronous reset between edges during a miss.
    if_enable = 1'b1; if_addr = 32'h0000_4000;
    step();
    if_enable = 1'b0;
    chk("areset_pre_req", {31'b0, mem_req}, 32'd1);
    #3 rst_in = 1'b0;
    #1;
    chk("areset_req_now", {31'b0, mem_req}, 32'd0);
    chk("areset_addr_now", mem_addr, 32'd0);
    step();
    rst_in = 1'b1;
    fetch(32'h0000_1004, 1'b0, 32'h0, 32'h1004_1004, 1, 1'b0, 1'b0);

    // Random fetches against the line-level model.
    reset_dut();
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a, md;
      int unsigned idx;
      logic        h, dc;
      a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2)
          | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a | 32'hFFFF_0000;
      idx = (a >> 2) % 64;
      h   = m_valid[idx] && (m_tag[idx] == (a >> 8));
      dc  = ($urandom_range(0, 7) == 0);
      md  = memf(a);
      fetch(a, h, m_data[idx], md, $urandom_range(0, 4), dc, 1'b1);
      if (!h) begin
        m_valid[idx] = 1'b1;
        m_tag[idx]   = a >> 8;
        m_data[idx]  = md;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
